imm_narrow: RTL and testbench

- Streaming 32-to-16-bit narrowing unit; the inverse direction of the MIPS sign extender.
- Converts 32-bit datapath values into 16-bit immediate/halfword form. Range-checks each value and either truncates or saturates it.
- Sits between the ALU result path and halfword store / immediate re-encode logic.
- Uses a valid/ready handshake with a single output register stage. Keeps a sticky overflow flag and an overflow counter for debug.

---
 rtl/imm_narrow.sv | 102 ++++++++++
 tb/tb_imm_narrow.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_narrow.sv
// rtl/imm_narrow.sv - streaming 32-to-16-bit narrowing unit with range check and saturation
//
// Ports:
//   clk, reset     : clock; synchronous active-high reset
//   in_valid/ready : input handshake; in_ready = !out_valid || out_ready, low during reset
//   in_data        : 32-bit value to narrow
//   in_signed      : 1 = two's complement range check, 0 = unsigned
//   in_sat         : 1 = saturate on overflow, 0 = truncate to in_data[15:0]
//   out_valid/ready: output handshake, single register stage, 1-cycle latency
//   out_data       : 16-bit narrowed result
//   out_ovf        : per-item overflow flag for out_data
//   ovf_sticky     : set by any accepted overflowing item
//   ovf_count      : accepted overflowing items, saturating at all-ones
//   clr            : synchronous clear of ovf_sticky / ovf_count
module imm_narrow #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_signed,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_ovf,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             clr
);

    logic             r_out_valid;
    logic [15:0]      r_out_data;
    logic             r_out_ovf;
    logic             r_sticky;
    logic [CNT_W-1:0] r_count;

    logic             w_accept;
    logic             w_fits;
    logic [15:0]      w_sat_val;
    logic [15:0]      w_narrow;

    // Reset gates in_ready so nothing is taken on the edge that flushes the stage.
    assign in_ready = !reset && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // Signed: the upper 17 bits must be a pure sign extension of bit 15.
    always_comb begin
        w_fits = 1'b0;
        if (in_signed) begin
            w_fits = (&in_data[31:15]) || !(|in_data[31:15]);
        end else begin
            w_fits = !(|in_data[31:16]);
        end
    end

    always_comb begin
        w_sat_val = 16'hFFFF;
        if (in_signed) begin
            w_sat_val = in_data[31] ? 16'h8000 : 16'h7FFF;
        end
    end

    assign w_narrow = (w_fits || !in_sat) ? in_data[15:0] : w_sat_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 16'h0000;
            r_out_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_narrow;
            r_out_ovf   <= !w_fits;
        end else if (out_ready) begin
            // Drained without a replacement: data is left as-is, only valid drops.
            r_out_valid <= 1'b0;
        end
    end

    // clr takes priority over a coincident overflowing accept.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_sticky <= 1'b0;
            r_count  <= '0;
        end else if (w_accept && !w_fits) begin
            r_sticky <= 1'b1;
            if (r_count != {CNT_W{1'b1}}) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_ovf    = r_out_ovf;
    assign ovf_sticky = r_sticky;
    assign ovf_count  = r_count;

endmodule

// File: tb/tb_imm_narrow.sv
// tb/tb_imm_narrow.sv - randomized and directed self-checking bench for imm_narrow
module tb_imm_narrow;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic        in_signed = 1'b0;
    logic        in_sat = 1'b0;
    logic        out_ready = 1'b0;
    logic        clr = 1'b0;

    logic        in_ready, out_valid, out_ovf, ovf_sticky;
    logic [15:0] out_data;
    logic [15:0] ovf_count;

    logic        in_ready2, out_valid2, out_ovf2, ovf_sticky2;
    logic [15:0] out_data2;
    logic [1:0]  ovf_count2;

    int total = 0;
    int bad = 0;

    // Transaction-level reference state
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_ovf;
    logic        m_sticky;
    int          m_cnt;
    int          m_cnt2;

    always #5 clk = ~clk;

    imm_narrow #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_signed(in_signed), .in_sat(in_sat),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count), .clr(clr)
    );

    imm_narrow #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_signed(in_signed), .in_sat(in_sat),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .out_ovf(out_ovf2), .ovf_sticky(ovf_sticky2), .ovf_count(ovf_count2), .clr(clr)
    );

    // Range check by integer value: returns {ovf, data}
    function automatic logic [16:0] ref_narrow(input logic [31:0] d, input logic sg, input logic sat);
        longint v, lo, hi;
        if (sg) begin
            v = longint'($signed(d));
            lo = -32768;
            hi = 32767;
        end else begin
            v = longint'(d);
            lo = 0;
            hi = 65535;
        end
        if (v >= lo && v <= hi) return {1'b0, d[15:0]};
        if (!sat) return {1'b1, d[15:0]};
        if (v > hi) return sg ? {1'b1, 16'h7FFF} : {1'b1, 16'hFFFF};
        return {1'b1, 16'h8000};
    endfunction

    // One clock: drive, compare everything at the negedge, then advance the model.
    task automatic drive_cycle(input logic v, input logic [31:0] d, input logic sg, input logic sat,
                               input logic ordy, input logic c, input logic rst);
        logic        exp_rdy;
        logic [16:0] r;
        in_valid = v; in_data = d; in_signed = sg; in_sat = sat;
        out_ready = ordy; clr = c; reset = rst;
        @(negedge clk);
        exp_rdy = !rst && (!m_valid || ordy);
        total++;
        if (in_ready !== exp_rdy || in_ready2 !== exp_rdy) begin
            bad++;
            $display("FAIL in_ready: got %b/%b want %b", in_ready, in_ready2, exp_rdy);
        end
        total++;
        if (out_valid !== m_valid || out_valid2 !== m_valid) begin
            bad++;
            $display("FAIL out_valid: got %b/%b want %b", out_valid, out_valid2, m_valid);
        end
        total++;
        if (out_data !== m_data || out_data2 !== m_data || out_ovf !== m_ovf || out_ovf2 !== m_ovf) begin
            bad++;
            $display("FAIL out_data: got %h/%h ovf %b/%b want %h ovf %b",
                     out_data, out_data2, out_ovf, out_ovf2, m_data, m_ovf);
        end
        total++;
        if (ovf_sticky !== m_sticky || ovf_sticky2 !== m_sticky ||
            ovf_count !== 16'(m_cnt) || ovf_count2 !== 2'(m_cnt2)) begin
            bad++;
            $display("FAIL counters: sticky %b/%b count %0d/%0d want sticky %b count %0d/%0d",
                     ovf_sticky, ovf_sticky2, ovf_count, ovf_count2, m_sticky, m_cnt, m_cnt2);
        end
        @(posedge clk);
        r = ref_narrow(d, sg, sat);
        if (rst) begin
            m_valid = 1'b0; m_data = 16'h0; m_ovf = 1'b0;
            m_sticky = 1'b0; m_cnt = 0; m_cnt2 = 0;
        end else begin
            if (v && exp_rdy) begin
                m_valid = 1'b1; m_data = r[15:0]; m_ovf = r[16];
            end else if (ordy) begin
                m_valid = 1'b0;
            end
            if (c) begin
                m_sticky = 1'b0; m_cnt = 0; m_cnt2 = 0;
            end else if (v && exp_rdy && r[16]) begin
                m_sticky = 1'b1;
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, ordy, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        total++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || ovf_count !== 16'd0 || ovf_sticky !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: valid %b data %h count %0d sticky %b want 0 0000 0 0",
                     out_valid, out_data, ovf_count, ovf_sticky);
        end
        drive_cycle(1'b1, 32'h00000005, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'h0005 || out_ovf !== 1'b0) begin
            bad++;
            $display("FAIL first_item: valid %b data %h ovf %b want 1 0005 0", out_valid, out_data, out_ovf);
        end
        idle(1'b1);
    endtask

    task automatic test_signed_bounds;
        logic [31:0] din [4] = '{32'h00007FFF, 32'hFFFF8000, 32'h00008000, 32'hFFFF7FFF};
        logic [15:0] dexp[4] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
        logic        oexp[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, din[i], 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            total++;
            if (out_data !== dexp[i] || out_ovf !== oexp[i] || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL signed_bound[%0d]: data %h ovf %b want %h %b", i, out_data, out_ovf, dexp[i], oexp[i]);
            end
        end
        total++;
        if (ovf_count !== 16'd2 || ovf_sticky !== 1'b1) begin
            bad++;
            $display("FAIL signed_counters: count %0d sticky %b want 2 1", ovf_count, ovf_sticky);
        end
        idle(1'b1);
    endtask

    task automatic test_unsigned_trunc;
        logic [31:0] din [4] = '{32'h0000FFFF, 32'h00010000, 32'h00012345, 32'hFFFFFFFF};
        logic        sg  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic        st  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [15:0] dexp[4] = '{16'hFFFF, 16'hFFFF, 16'h2345, 16'hFFFF};
        logic        oexp[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, din[i], sg[i], st[i], 1'b1, 1'b0, 1'b0);
            total++;
            if (out_data !== dexp[i] || out_ovf !== oexp[i]) begin
                bad++;
                $display("FAIL unsigned_trunc[%0d]: data %h ovf %b want %h %b", i, out_data, out_ovf, dexp[i], oexp[i]);
            end
        end
        idle(1'b1);
    endtask

    task automatic test_back_to_back;
        logic [31:0] items[5] = '{32'h00000011, 32'h00000022, 32'hFFFFFFF0, 32'h00010000, 32'h00000044};
        logic [15:0] iexp [5] = '{16'h0011, 16'h0022, 16'hFFF0, 16'h7FFF, 16'h0044};
        drive_cycle(1'b1, 32'h0000ABCD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, items[0], 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            total++;
            if (in_ready !== 1'b0 || out_data !== 16'hABCD || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL backpressure[%0d]: in_ready %b data %h valid %b want 0 abcd 1",
                         i, in_ready, out_data, out_valid);
            end
        end
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, items[i], 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            total++;
            if (out_valid !== 1'b1 || out_data !== iexp[i]) begin
                bad++;
                $display("FAIL stream[%0d]: valid %b data %h want 1 %h", i, out_valid, out_data, iexp[i]);
            end
        end
        idle(1'b1);
        total++;
        if (out_valid !== 1'b0 || out_data !== 16'h0044) begin
            bad++;
            $display("FAIL drain_hold: valid %b data %h want 0 0044", out_valid, out_data);
        end
    endtask

    task automatic test_clr;
        drive_cycle(1'b1, 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h12345678, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        total++;
        if (out_data !== 16'h7FFF || out_ovf !== 1'b1 || ovf_sticky !== 1'b0 || ovf_count !== 16'd0) begin
            bad++;
            $display("FAIL clr_wins: data %h ovf %b sticky %b count %0d want 7fff 1 0 0",
                     out_data, out_ovf, ovf_sticky, ovf_count);
        end
        idle(1'b1);
    endtask

    task automatic test_reset_mid;
        drive_cycle(1'b1, 32'h00020000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h00000001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        total++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || ovf_count !== 16'd0 || ovf_sticky !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: valid %b data %h count %0d sticky %b want 0 0000 0 0",
                     out_valid, out_data, ovf_count, ovf_sticky);
        end
        out_ready = 1'b0; reset = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset: in_ready %b want 1", in_ready);
        end
        idle(1'b1);
    endtask

    task automatic test_count_saturate;
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 32'hDEAD0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        total++;
        if (ovf_count2 !== 2'd3 || ovf_count !== 16'd5) begin
            bad++;
            $display("FAIL count_saturate: narrow %0d wide %0d want 3 5", ovf_count2, ovf_count);
        end
        idle(1'b1);
    endtask

    task automatic test_random;
        logic [31:0] d;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 4))
                0: d = $urandom_range(0, 32'h0001FFFF);
                1: d = 32'hFFFF0000 | $urandom_range(0, 32'h0000FFFF);
                2: d = 32'h00007FF0 + $urandom_range(0, 32);
                3: d = 32'hFFFF7FF0 + $urandom_range(0, 32);
                default: d = $urandom;
            endcase
            drive_cycle($urandom_range(0, 3) != 0, d, 1'($urandom), 1'($urandom),
                        $urandom_range(0, 3) != 0, $urandom_range(0, 30) == 0,
                        $urandom_range(0, 80) == 0);
        end
    endtask

    initial begin
        m_valid = 1'b0; m_data = 16'h0; m_ovf = 1'b0; m_sticky = 1'b0; m_cnt = 0; m_cnt2 = 0;
        @(posedge clk);
        #1;
        test_reset;
        test_signed_bounds;
        test_unsigned_trunc;
        test_back_to_back;
        test_clr;
        test_reset_mid;
        test_count_saturate;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
